// File: rtl/uart_banner_soc.sv
// uart_banner_soc: chip-level serial top. Sends a fixed "HELLO\r\n" banner
// after reset, then echoes every correctly framed byte received on serial_rx.
// 8N1 framing, DIV = round(CLK_FREQ/BAUD) clock cycles per bit.
module uart_banner_soc #(
  parameter int unsigned CLK_FREQ = 16000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic clk16,
  input  logic rst,
  input  logic serial_rx,
  output logic serial_tx
);

  localparam int unsigned DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV);

  localparam logic       SEQ_BANNER = 1'b0;
  localparam logic       SEQ_ECHO   = 1'b1;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Transmitter state
  logic             tx_busy_q, tx_busy_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [8:0]       tx_shift_q, tx_shift_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_ready_c, tx_load_c;
  logic [7:0]       tx_data_c;

  // Sequencer state
  logic             seq_q, seq_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       rom_c;

  // Receiver state
  logic [1:0]       sync_q, sync_d;
  logic             rx_prev_q, rx_prev_d;
  logic [1:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_push_c;

  // Echo FIFO state
  logic [3:0][7:0]  fifo_mem_q, fifo_mem_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       fifo_cnt_q, fifo_cnt_d;
  logic             fifo_push_c, fifo_pop_c;

  assign serial_tx = tx_line_q;

  // Ready during the last stop-bit cycle so consecutive frames abut
  assign tx_ready_c = !tx_busy_q ||
                      ((tx_cnt_q == CNT_W'(DIV - 1)) && (tx_bit_q == 4'd9));

  // Banner ROM
  always_comb begin
    rom_c = 8'h00;
    case (idx_q)
      3'd0:    rom_c = 8'h48;
      3'd1:    rom_c = 8'h45;
      3'd2:    rom_c = 8'h4C;
      3'd3:    rom_c = 8'h4C;
      3'd4:    rom_c = 8'h4F;
      3'd5:    rom_c = 8'h0D;
      3'd6:    rom_c = 8'h0A;
      default: rom_c = 8'h00;
    endcase
  end

  // Sequencer: banner once, then drain the echo FIFO into the transmitter
  always_comb begin
    seq_d      = seq_q;
    idx_d      = idx_q;
    tx_load_c  = 1'b0;
    tx_data_c  = rom_c;
    fifo_pop_c = 1'b0;
    case (seq_q)
      SEQ_BANNER: begin
        if (tx_ready_c) begin
          tx_load_c = 1'b1;
          if (idx_q == 3'd6) seq_d = SEQ_ECHO;
          else               idx_d = idx_q + 3'd1;
        end
      end
      default: begin
        if (tx_ready_c && (fifo_cnt_q != 3'd0)) begin
          tx_load_c  = 1'b1;
          tx_data_c  = fifo_mem_q[rd_ptr_q];
          fifo_pop_c = 1'b1;
        end
      end
    endcase
  end

  // Transmitter: start bit, 8 data bits LSB first, stop bit, DIV cycles each
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    if (tx_load_c) begin
      tx_busy_d  = 1'b1;
      tx_cnt_d   = '0;
      tx_bit_d   = 4'd0;
      tx_shift_d = {1'b1, tx_data_c};
      tx_line_d  = 1'b0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == CNT_W'(DIV - 1)) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          tx_line_d = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 4'd1;
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[8:1]};
        end
      end else begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
    end
  end

  // Receiver: synchronise, detect start edge, validate at half bit, sample mid-bit
  always_comb begin
    sync_d     = {sync_q[0], serial_rx};
    rx_prev_d  = sync_q[1];
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_W'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push_c  = 1'b0;
    case (rx_state_q)
      RX_START: begin
        if (rx_cnt_q == CNT_W'(HALF - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = sync_q[1] ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_W'(DIV - 1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync_q[1], rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_W'(DIV - 1)) begin
          rx_cnt_d   = '0;
          rx_push_c  = sync_q[1];
          rx_state_d = RX_IDLE;
        end
      end
      default: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !sync_q[1]) rx_state_d = RX_START;
      end
    endcase
  end

  // Echo FIFO: drop on full unless a pop frees the slot in the same cycle
  assign fifo_push_c = rx_push_c && ((fifo_cnt_q != 3'd4) || fifo_pop_c);

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_push_c) begin
      fifo_mem_d[wr_ptr_q] = rx_shift_q;
      wr_ptr_d             = wr_ptr_q + 2'd1;
    end
    if (fifo_pop_c) rd_ptr_d = rd_ptr_q + 2'd1;
    case ({fifo_push_c, fifo_pop_c})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk16 or posedge rst) begin
    if (rst) begin
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 4'd0;
      tx_shift_q <= '1;
      tx_line_q  <= 1'b1;
      seq_q      <= SEQ_BANNER;
      idx_q      <= 3'd0;
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      fifo_mem_q <= '0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      fifo_cnt_q <= 3'd0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      seq_q      <= seq_d;
      idx_q      <= idx_d;
      sync_q     <= sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_banner_soc.sv
// Testbench for uart_banner_soc: a serial-line monitor decodes serial_tx and
// compares each frame against a scoreboard queue filled as stimulus is driven.
`timescale 1ns/1ps
module tb_uart_banner_soc;

  localparam int DIV  = 139;
  localparam int HALF = DIV / 2;

  logic clk16;
  logic rst;
  logic serial_rx;
  logic serial_tx;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];
  bit         lossy = 1'b0;
  int         lossy_cnt = 0;

  // Monitor state
  bit         mon_busy = 1'b0;
  logic       mon_prev = 1'b1;
  int         mon_cnt = 0;
  logic       mon_level = 1'b0;
  bit         mon_werr = 1'b0;
  logic       mon_stop = 1'b0;
  logic [7:0] mon_data = 8'h00;
  int         mon_frames = 0;
  int         mon_start_cyc = 0;

  uart_banner_soc dut (
    .clk16     (clk16),
    .rst       (rst),
    .serial_rx (serial_rx),
    .serial_tx (serial_tx)
  );

  initial clk16 = 1'b0;
  always #5 clk16 = ~clk16;

  initial forever begin
    @(posedge clk16);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] banner_byte(input int i);
    case (i)
      0: return 8'h48;
      1: return 8'h45;
      2: return 8'h4C;
      3: return 8'h4C;
      4: return 8'h4F;
      5: return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  // Decode serial_tx frames on the falling clock edge and score them
  initial forever begin
    int pos;
    int bitn;
    logic [7:0] e;
    bit found;
    @(negedge clk16);
    if (rst) begin
      mon_busy = 1'b0;
      mon_prev = 1'b1;
    end else if (!mon_busy) begin
      if (mon_prev && !serial_tx) begin
        mon_busy      = 1'b1;
        mon_cnt       = 1;
        mon_level     = 1'b0;
        mon_werr      = 1'b0;
        mon_start_cyc = cyc;
      end
      mon_prev = serial_tx;
    end else begin
      pos  = mon_cnt % DIV;
      bitn = mon_cnt / DIV;
      if (pos == 0) mon_level = serial_tx;
      else if (serial_tx !== mon_level) mon_werr = 1'b1;
      if (pos == HALF && bitn >= 1 && bitn <= 8) mon_data[bitn-1] = serial_tx;
      if (pos == HALF && bitn == 9) mon_stop = serial_tx;
      if (mon_cnt == 10 * DIV - 1) begin
        mon_busy = 1'b0;
        mon_prev = serial_tx;
        mon_frames++;
        check_eq("frame_format", {30'd0, mon_werr, mon_stop}, 32'd1);
        if (lossy) begin
          found = 1'b0;
          while (exp_q.size() != 0 && !found) begin
            e = exp_q.pop_front();
            if (e == mon_data) found = 1'b1;
          end
          lossy_cnt++;
          check_eq("lossy_in_order", 32'(found), 32'd1);
        end else begin
          check_eq("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("tx_byte", 32'(mon_data), 32'(e));
          end
        end
      end else begin
        mon_cnt++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial_rx = fr[i];
      repeat (DIV) @(negedge clk16);
    end
    serial_rx = 1'b1;
  endtask

  // Assert reset, release it, queue the banner and check start-bit latency
  task automatic reset_and_banner(input int hold);
    int n;
    @(posedge clk16);
    #1 rst = 1'b1;
    #1 check_eq("tx_high_in_reset", 32'(serial_tx), 32'd1);
    repeat (hold) @(posedge clk16);
    #1 rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(banner_byte(i));
    n = 0;
    while (serial_tx && n < 8) begin
      @(negedge clk16);
      n++;
    end
    check_eq("start_latency_ok", 32'(n <= 4), 32'd1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk16);
      n++;
    end
    check_eq(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int base;
    int t0;
    int n;
    bit low_seen;
    rst       = 1'b1;
    serial_rx = 1'b1;
    #20;
    // Power-on banner
    reset_and_banner(2);
    wait_drain("banner_drain", 12000);
    low_seen = 1'b0;
    repeat (3 * DIV) begin
      @(negedge clk16);
      if (!serial_tx) low_seen = 1'b1;
    end
    check_eq("idle_high_after_banner", 32'(low_seen), 32'd0);

    // Single echo, must start after the RX stop-bit sample
    base = mon_frames;
    exp_q.push_back(8'h41);
    t0 = cyc;
    send_byte(8'h41, 1'b1);
    wait_drain("echo41_drain", 4000);
    check_eq("echo41_frames", 32'(mon_frames), 32'(base + 1));
    check_eq("echo41_timing",
             32'(mon_start_cyc >= t0 + 9 * DIV + HALF && mon_start_cyc <= t0 + 10 * DIV + 10),
             32'd1);

    // Framing error discarded, following byte echoed
    base = mon_frames;
    send_byte(8'h55, 1'b0);
    repeat (DIV) @(negedge clk16);
    exp_q.push_back(8'h33);
    send_byte(8'h33, 1'b1);
    wait_drain("framing_drain", 4000);
    check_eq("framing_frames", 32'(mon_frames), 32'(base + 1));

    // Burst of back-to-back bytes: in order, no duplicates, at least a FIFO's worth
    lossy     = 1'b1;
    lossy_cnt = 0;
    exp_q.delete();
    for (int i = 1; i <= 6; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1);
    repeat (3 * 10 * DIV) @(negedge clk16);
    n = 0;
    while (mon_busy && n < 20 * DIV) begin
      @(negedge clk16);
      n++;
    end
    check_eq("burst_count_ok", 32'(lossy_cnt >= 4 && lossy_cnt <= 6), 32'd1);
    lossy = 1'b0;
    exp_q.delete();

    // Short glitch must not start a byte
    base = mon_frames;
    serial_rx = 1'b0;
    repeat (DIV / 4) @(negedge clk16);
    serial_rx = 1'b1;
    repeat (15 * DIV) @(negedge clk16);
    check_eq("glitch_no_echo", 32'(mon_frames), 32'(base));

    // Byte received during banner is echoed after it
    reset_and_banner(1);
    repeat (5 * DIV) @(negedge clk16);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    wait_drain("banner_7e_drain", 13000);

    // Reset in the middle of banner byte 2 restarts the banner cleanly
    reset_and_banner(1);
    base = mon_frames;
    n = 0;
    while (!(mon_frames == base + 2 && mon_busy && mon_cnt > 5 * DIV) && n < 5 * 10 * DIV) begin
      @(negedge clk16);
      n++;
    end
    check_eq("mid_byte2_reached", 32'(n < 5 * 10 * DIV), 32'd1);
    reset_and_banner(1);
    wait_drain("restart_drain", 12000);
    repeat (2 * DIV) @(negedge clk16);
    check_eq("sb_empty_at_end", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_banner_soc.md
Name: uart_banner_soc

Overview:
- Minimal serial SoC top: after reset it transmits a fixed ASCII banner on serial_tx.
- It then echoes every correctly framed byte received on serial_rx.
- Contents: 8N1 UART transmitter, UART receiver, banner ROM, 4-entry echo FIFO and a small sequencer.
- Sits at chip level; pins map directly to board clock, reset button and UART pads.

Parameters:
- CLK_FREQ, 16000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- DIV (derived, not overridable), round(CLK_FREQ/BAUD) = 139 at defaults; clock cycles per bit.

Ports:
- clk16  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- serial_rx  input  1  UART receive line, idle high, asynchronous to clk16.
- serial_tx  output  1  UART transmit line, idle high.

Behaviour:
- Clocking/reset: one clock, clk16. Reset is asynchronous and active-high; every flop clears immediately on rst high.
- Reset values: serial_tx=1, FIFO empty, RX idle, sequencer in BANNER at index 0.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly DIV cycles, so a frame is 10*DIV cycles.
- TX:
  - Idle drives 1.
  - On load it drives the start bit on the next cycle and holds the byte internally.
  - Back-to-back frames have no idle gap between stop bit and next start bit.
- Banner ROM: 7 bytes, "HELLO\r\n" = 0x48 0x45 0x4C 0x4C 0x4F 0x0D 0x0A.
- Sequencer states: BANNER -> ECHO.
  - BANNER: loads TX with ROM[idx] whenever TX is idle; idx increments. After byte 6 is loaded, moves to ECHO; the banner is never resent except after reset.
  - Timing: first start bit appears (serial_tx falls) within 4 cycles of rst deassertion.
  - ECHO: when TX idle and FIFO non-empty, pops the head byte and loads TX.
- RX:
  - serial_rx passes through a 2-flop synchronizer.
  - A falling edge in idle starts the DIV counter. The line is sampled at DIV/2 (integer) to validate start; if high, the start is false and RX returns to idle.
  - Data and stop bits are sampled every DIV cycles thereafter, at mid-bit.
  - Stop bit 1: byte pushed to FIFO. Stop bit 0 (framing error): byte discarded.
  - RX becomes ready for a new start edge right after the stop-bit sample.
- FIFO:
  - 4 entries x 8 bits.
  - Push while full: new byte dropped, contents unchanged.
  - Simultaneous push and pop: both take effect; count unchanged.
  - RX bytes received during BANNER are queued and echoed after the banner.
- Reset mid-operation: serial_tx returns to 1 asynchronously; a partial frame is abandoned; the banner restarts from index 0 after release.
- No other outputs; no parity; no flow control.

Test Plan:
- Hold rst=1, rx=1 for 20 ns, release -> serial_tx=1 during reset; start bit within 4 cycles after release; decoded bytes 0x48,0x45,0x4C,0x4C,0x4F,0x0D,0x0A, each bit 139 cycles wide; line then idles high.
- After banner, drive rx frame 0x41 at DIV-cycle bit period -> exactly one frame 0x41 on serial_tx, starting after the RX stop-bit sample.
- Drive frame 0x55 with stop bit 0 -> nothing transmitted; then a valid 0x33 -> echo 0x33 only.
- Drive 6 back-to-back valid bytes 0x01..0x06 while TX is busy echoing -> bytes dropped only when the FIFO is full; every transmitted byte is in order and is one of the sent values, with no duplication.
- Send 0x7E during banner transmission -> full 7-byte banner first, then 0x7E.
- Pulse rst for 1 cycle in the middle of banner byte 2 -> serial_tx=1 immediately; banner restarts from 0x48; no corrupted trailing frame.
- rx glitch low for DIV/4 cycles in idle -> no byte received, nothing echoed.
